// File: rtl/sw_key_input_pio_pkg.sv
// rtl/sw_key_input_pio_pkg.sv - register map and edge-mode types for the switch/key input PIO
package sw_key_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE     = 2'd2;
    localparam logic [1:0] ADDR_RAW      = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

endpackage

// File: rtl/sw_key_input_pio_if.sv
// rtl/sw_key_input_pio_if.sv - Avalon-MM slave bus bundle for the switch/key input PIO
interface sw_key_input_pio_if;

    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/sw_key_input_pio_debounce_bit.sv
// rtl/sw_key_input_pio_debounce_bit.sv - one input bit: synchroniser, debounce counter, data flop
module sw_debounce_bit #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic sync,
    output logic data,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   data_q, data_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_BIT}};
            cnt_q  <= '0;
            data_q <= RESET_BIT;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Any sample agreeing with the accepted level restarts the stability count.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (sync == data_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            data_d = sync;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign data = data_q;
    assign rise = data_d & ~data_q;
    assign fall = ~data_d & data_q;

endmodule

// File: rtl/sw_key_input_pio.sv
// rtl/sw_key_input_pio.sv - debounced switch/key input peripheral with edge capture and irq
module sw_key_input_pio
    import sw_key_pio_pkg::*;
#(
    parameter int               WIDTH           = 10,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_MODE       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     pins_in,
    sw_key_input_pio_if.slave    avs,
    output logic                 irq
);

    localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE);

    logic [WIDTH-1:0] sync_bits, data_bits, rise_bits, fall_bits;
    logic [WIDTH-1:0] edge_set, edge_clr;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] irq_mask_q;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q;
    logic             wr_mask, wr_edge;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[i])
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (pins_in[i]),
            .sync    (sync_bits[i]),
            .data    (data_bits[i]),
            .rise    (rise_bits[i]),
            .fall    (fall_bits[i])
        );
    end

    if (WIDTH < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^avs.avs_writedata[31:WIDTH];
    end

    always_comb begin
        edge_set = '0;
        case (MODE)
            EDGE_RISE: edge_set = rise_bits;
            EDGE_FALL: edge_set = fall_bits;
            default:   edge_set = rise_bits | fall_bits;
        endcase
    end

    assign wr_mask  = avs.avs_write && (avs.avs_address == ADDR_IRQ_MASK);
    assign wr_edge  = avs.avs_write && (avs.avs_address == ADDR_EDGE);
    assign edge_clr = wr_edge ? avs.avs_writedata[WIDTH-1:0] : '0;
    // Set is applied after the clear so a fresh edge survives a same-cycle W1C.
    assign edge_d   = (edge_q & ~edge_clr) | edge_set;

    always_comb begin
        readdata_d = '0;
        case (avs.avs_address)
            ADDR_DATA:     readdata_d[WIDTH-1:0] = data_bits;
            ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE:     readdata_d[WIDTH-1:0] = edge_q;
            default:       readdata_d[WIDTH-1:0] = sync_bits;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q     <= '0;
            irq_mask_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            edge_q <= edge_d;
            if (wr_mask) begin
                irq_mask_q <= avs.avs_writedata[WIDTH-1:0];
            end
            if (avs.avs_read) begin
                readdata_q <= readdata_d;
            end
            irq_q <= |(edge_q & irq_mask_q);
        end
    end

    assign avs.avs_readdata = readdata_q;
    assign irq              = irq_q;

endmodule

// File: tb/tb_sw_key_input_pio.sv
// tb/tb_sw_key_input_pio.sv - directed self-checking bench for sw_key_input_pio
module tb_sw_key_input_pio;
    import sw_key_pio_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [9:0] pins_in;
    logic       irq;
    logic [31:0] rd;
    int tests;
    int fails;

    sw_key_input_pio_if bus ();

    sw_key_input_pio #(
        .WIDTH           (10),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .EDGE_MODE       (2),
        .RESET_VALUE     (10'h000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pins_in (pins_in),
        .avs     (bus.slave),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        pins_in = 10'h000;
        bus.avs_address   = 2'd0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = 32'h0;
        #20 reset_n = 1'b1;
        #1;
        check("reset_readdata", bus.avs_readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        bus_read(ADDR_DATA, rd);
        check("reset_data", rd, 32'h000);
        bus_read(ADDR_EDGE, rd);
        check("reset_edge", rd, 32'h000);

        // all pins high: sync after 2 edges, debounced after exactly 6
        pins_in = 10'h3FF;
        tick(1);
        check("raw_after_1", {22'h0, dut.sync_bits}, 32'h000);
        tick(1);
        check("raw_after_2", {22'h0, dut.sync_bits}, 32'h3FF);
        tick(3);
        check("data_after_5", {22'h0, dut.data_bits}, 32'h000);
        tick(1);
        check("data_after_6", {22'h0, dut.data_bits}, 32'h3FF);
        bus_read(ADDR_RAW, rd);
        check("raw_reg", rd, 32'h3FF);
        bus_read(ADDR_DATA, rd);
        check("data_reg_3ff", rd, 32'h3FF);
        bus_read(ADDR_EDGE, rd);
        check("edge_reg_3ff", rd, 32'h3FF);
        bus_write(ADDR_EDGE, 32'h3FF);
        pins_in = 10'h000;
        tick(8);
        check("data_back_0", {22'h0, dut.data_bits}, 32'h000);
        bus_write(ADDR_EDGE, 32'hFFFF_FFFF);
        bus_read(ADDR_EDGE, rd);
        check("edge_cleared", rd, 32'h000);

        // 3-cycle glitch is filtered, 4-cycle pulse is accepted
        pins_in = 10'h008;
        tick(3);
        pins_in = 10'h000;
        tick(8);
        bus_read(ADDR_DATA, rd);
        check("glitch_data", rd, 32'h000);
        bus_read(ADDR_EDGE, rd);
        check("glitch_edge", rd, 32'h000);
        pins_in = 10'h008;
        tick(4);
        pins_in = 10'h000;
        tick(1);
        check("pulse4_data_early", {22'h0, dut.data_bits}, 32'h000);
        tick(1);
        check("pulse4_data", {22'h0, dut.data_bits}, 32'h008);
        tick(6);
        bus_read(ADDR_EDGE, rd);
        check("pulse4_edge", rd, 32'h008);
        bus_write(ADDR_EDGE, 32'h008);

        // irq path through mask, capture and W1C
        bus_write(ADDR_IRQ_MASK, 32'h001);
        pins_in = 10'h001;
        tick(5);
        check("irq_edge_pre", {22'h0, dut.edge_q}, 32'h000);
        tick(1);
        check("irq_edge_set", {22'h0, dut.edge_q}, 32'h001);
        check("irq_not_yet", {31'h0, irq}, 32'h0);
        tick(1);
        check("irq_rise", {31'h0, irq}, 32'h1);
        bus_write(ADDR_EDGE, 32'h001);
        check("w1c_edge", {22'h0, dut.edge_q}, 32'h000);
        check("irq_hold", {31'h0, irq}, 32'h1);
        tick(1);
        check("irq_fall", {31'h0, irq}, 32'h0);

        // W1C of bit 5 lands on the same edge bit 5 captures
        pins_in = 10'h021;
        tick(5);
        bus_write(ADDR_EDGE, 32'h020);
        bus_read(ADDR_EDGE, rd);
        check("set_beats_clear", rd, 32'h020);

        // back-to-back reads
        bus.avs_read    = 1'b1;
        bus.avs_address = ADDR_DATA;
        @(negedge clk);
        check("b2b_data", bus.avs_readdata, 32'h021);
        bus.avs_address = ADDR_IRQ_MASK;
        @(negedge clk);
        check("b2b_mask", bus.avs_readdata, 32'h001);
        bus.avs_address = ADDR_EDGE;
        @(negedge clk);
        check("b2b_edge", bus.avs_readdata, 32'h020);
        bus.avs_address = ADDR_RAW;
        @(negedge clk);
        check("b2b_raw", bus.avs_readdata, 32'h021);
        bus.avs_read    = 1'b0;
        tick(1);
        check("readdata_hold", bus.avs_readdata, 32'h021);
        bus_write(ADDR_DATA, 32'hFFFF_FFFF);
        bus_read(ADDR_DATA, rd);
        check("data_ro", rd, 32'h021);

        // read and write together: read returns the pre-write value
        bus.avs_writedata = 32'h3FF;
        bus.avs_write     = 1'b1;
        bus_read(ADDR_IRQ_MASK, rd);
        bus.avs_write     = 1'b0;
        check("rw_pre_value", rd, 32'h001);
        bus_read(ADDR_IRQ_MASK, rd);
        check("rw_post_value", rd, 32'h3FF);
        check("irq_mask_wide", {31'h0, irq}, 32'h1);

        // asynchronous reset mid-cycle
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_readdata", bus.avs_readdata, 32'h0);
        check("async_rst_irq", {31'h0, irq}, 32'h0);
        check("async_rst_data", {22'h0, dut.data_bits}, 32'h000);
        check("async_rst_edge", {22'h0, dut.edge_q}, 32'h000);
        #6 reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sw_key_input_pio.md
Name: sw_key_input_pio

Overview:
- Avalon-MM slave peripheral that lets the PULPino core read the board switches (SW) and push-buttons (KEY), i.e. the reader of the inputs the board/bench drives.
- Per-bit chain: synchroniser, then debounce filter, then debounced data register, then edge-capture register with maskable level interrupt.
- Sits in the Qsys system between the top-level SW/KEY pins and the core's data bus and interrupt line.

Parameters:
- WIDTH, 10: number of input bits (10 for SW, 4 for KEY).
- SYNC_STAGES, 2: flip-flops in the input synchroniser (legal range 2..4).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a change (1 ms at 50 MHz); legal range 1..2^20.
- EDGE_MODE, 2: 0 = rising edges captured, 1 = falling edges captured, 2 = both edges captured.
- RESET_VALUE, 0: WIDTH-bit reset value of the synchroniser and debounced data (use all-ones for active-low KEY).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- pins_in  in  WIDTH  raw asynchronous switch/key inputs.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; valid exactly 1 cycle after avs_read.
- irq  out  1  level interrupt to the core.

Behaviour:
- Reset, asynchronous on reset_n low:
  - synchroniser stages and debounced data = RESET_VALUE.
  - all debounce counters = 0; edge_capture = 0; irq_mask = 0; avs_readdata = 0; irq = 0.
- Synchroniser: SYNC_STAGES flops per bit. sync = last stage.
- Debounce, per bit i:
  - counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync[i] == data[i], cnt[i] is cleared to 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CYCLES-1, data[i] takes sync[i] and cnt[i] is cleared.
  - Otherwise cnt[i] increments.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches data.
  - Latency from pin change to data change = SYNC_STAGES + DEBOUNCE_CYCLES clk edges.
- Edge detect: rise = data_next & ~data; fall = ~data_next & data. The selected set per EDGE_MODE sets edge_capture bits on the same edge that data updates.
- Register map (word address; unused upper bits read 0):
  - 0 DATA: RO debounced data. Writes are ignored.
  - 1 IRQ_MASK: RW, WIDTH bits.
  - 2 EDGE_CAPTURE: read returns the bits; writing 1 clears the corresponding bit (W1C).
  - 3 RAW: RO synchronised, undebounced sync value. Writes are ignored.
- Reads: fixed latency 1. avs_readdata is registered on the avs_read cycle and holds its value until the next read.
- Simultaneous events:
  - Edge set and W1C clear of the same bit in the same cycle: set wins, bit stays 1.
  - avs_read and avs_write asserted together: both are performed. The read returns the pre-write value.
- irq = |(edge_capture & irq_mask), registered. It asserts 1 cycle after the capture/mask update and deasserts 1 cycle after the clear.
- Reset mid-debounce: the partial count is discarded. After release, the debounce restarts from 0 against RESET_VALUE.
- No wrap-around: the counter never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Package sw_key_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQ_MASK=1, ADDR_EDGE=2, ADDR_RAW=3.
  - edge_mode_e enum {EDGE_RISE, EDGE_FALL, EDGE_ANY}.
- Sub-module sw_debounce_bit: one bit of synchroniser plus counter plus data flop, with outputs data, rise, fall. Top level generates WIDTH instances and holds the register file, Avalon logic and irq.

Test Plan (WIDTH=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_MODE=2, 20 ns clock):
- Reset hold for 20 ns, then release: DATA reads 0x000, EDGE reads 0x000, irq=0. Asserting reset_n low mid-cycle clears outputs immediately, without waiting for a clk edge.
- pins_in 0x000 -> 0x3FF and held: RAW = 0x3FF after 2 edges. DATA = 0x3FF after exactly 6 edges, not 5. EDGE = 0x3FF.
- Glitch of pins_in[3] high for 3 cycles: DATA stays 0x000, EDGE stays 0x000. A 4-cycle pulse (after sync) sets DATA[3] = 1.
- Write IRQ_MASK = 0x001, then toggle bit 0: irq rises 1 cycle after EDGE[0] sets. Write EDGE = 0x001: EDGE = 0x000 and irq falls 1 cycle later.
- W1C of bit 5 on the same cycle bit 5 captures a new edge: EDGE[5] remains 1.
- Back-to-back reads of addresses 0..3 on consecutive cycles: each avs_readdata is valid 1 cycle after its read, with the correct value. A write to DATA leaves DATA unchanged.
